// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Game-round countdown clock. Divides CLK down to a 1 Hz tick and counts the
// remaining round time down from START_MIN:START_SEC to 0:00. It also applies
// wrong-answer time penalties and flags round expiry to game control.
//
// Parameters
//   CLK_FREQ     CLK cycles per second (prescaler terminal count), >= 2
//   START_MIN    reload minutes value, 0..63
//   START_SEC    reload seconds value, 0..59
//   PENALTY_SEC  seconds removed per penalty pulse, 1..255
//
// Ports
//   CLK      in   system clock
//   Reset    in   synchronous, active-high reset
//   start    in   1-cycle pulse: reload the start value and run (any state)
//   pause    in   level: while high, the countdown holds
//   penalty  in   1-cycle pulse: subtract PENALTY_SEC (saturating at 0)
//   minutes  out  remaining minutes, 0..63
//   seconds  out  remaining seconds, 0..59
//   tick     out  1-cycle pulse on every 1 s decrement
//   running  out  high while counting (not paused)
//   expired  out  high once the round time has run out
// ---------------------------------------------------------------------------
module countdown_timer #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int START_MIN   = 3,
    parameter int START_SEC   = 0,
    parameter int PENALTY_SEC = 10
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       start,
    input  logic       pause,
    input  logic       penalty,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       tick,
    output logic       running,
    output logic       expired
);

    localparam int              PW             = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   LAST_COUNT     = PW'(CLK_FREQ - 1);
    localparam logic [11:0]     RELOAD_TOTAL   = 12'(START_MIN * 60 + START_SEC);
    localparam logic [5:0]      RELOAD_MIN     = 6'(START_MIN);
    localparam logic [5:0]      RELOAD_SEC     = 6'(START_SEC);
    localparam logic [11:0]     PENALTY_AMOUNT = 12'(PENALTY_SEC);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    state_t        state;
    logic [11:0]   total;
    logic [PW-1:0] prescaler;

    logic          active;
    logic          advance;
    logic          wrap;
    logic [11:0]   decrement;
    logic [11:0]   nextTotal;
    logic [5:0]    nextMin;
    logic [5:0]    nextSec;

    // Works out what the counting states would do this cycle. The prescaler
    // only advances on cycles where pause is low, so a pause costs no time
    // from the current second: the count resumes with the cycles it had left.
    // A penalty landing on the terminal count removes both amounts at once,
    // and the result saturates at zero. Minutes/seconds are derived from the
    // new total so they always change on the same edge as the total itself.
    always_comb begin
        active    = (state == RUNNING) || (state == PAUSED);
        advance   = active && !pause;
        wrap      = advance && (prescaler == LAST_COUNT);
        decrement = (wrap ? 12'd1 : 12'd0) + ((active && penalty) ? PENALTY_AMOUNT : 12'd0);
        nextTotal = (total > decrement) ? (total - decrement) : 12'd0;
        nextMin   = 6'(nextTotal / 12'd60);
        nextSec   = 6'(nextTotal % 12'd60);
    end

    // Main state machine with registered outputs. Reset beats everything,
    // then start (from any state, including over a simultaneous pause), then
    // the per-state behaviour. A zero reload value goes straight to EXPIRED
    // because there is nothing to count.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            total     <= RELOAD_TOTAL;
            minutes   <= RELOAD_MIN;
            seconds   <= RELOAD_SEC;
            prescaler <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else if (start) begin
            total     <= RELOAD_TOTAL;
            minutes   <= RELOAD_MIN;
            seconds   <= RELOAD_SEC;
            prescaler <= '0;
            tick      <= 1'b0;
            if (RELOAD_TOTAL == 12'd0) begin
                state   <= EXPIRED;
                running <= 1'b0;
                expired <= 1'b1;
            end else begin
                state   <= RUNNING;
                running <= 1'b1;
                expired <= 1'b0;
            end
        end else begin
            case (state)
                RUNNING, PAUSED: begin
                    tick    <= wrap;
                    total   <= nextTotal;
                    minutes <= nextMin;
                    seconds <= nextSec;
                    if (advance) begin
                        prescaler <= wrap ? '0 : prescaler + PW'(1);
                    end
                    if (nextTotal == 12'd0) begin
                        state   <= EXPIRED;
                        running <= 1'b0;
                        expired <= 1'b1;
                    end else if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                end
                IDLE, EXPIRED: begin
                    tick <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    tick    <= 1'b0;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule
